// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int WDOG_W = 16;

    function automatic logic any_term(input logic ack, input logic err, input logic rty);
        return ack | err | rty;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after last+1 (mod N) wins.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int cand;
        cand   = 0;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: N masters share one slave, owner holds the bus while its cyc is high.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS  = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_MASTERS-1:0]              m_cyc,
    input  logic [NUM_MASTERS-1:0]              m_stb,
    input  logic [NUM_MASTERS-1:0]              m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_o,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0] m_sel,
    output logic [NUM_MASTERS-1:0]              m_ack,
    output logic [NUM_MASTERS-1:0]              m_err,
    output logic [NUM_MASTERS-1:0]              m_rty,
    output logic [DATA_WIDTH-1:0]               m_dat_i,
    output logic                                s_cyc,
    output logic                                s_stb,
    output logic                                s_we,
    output logic [ADDR_WIDTH-1:0]               s_adr,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic [SELECT_WIDTH-1:0]             s_sel,
    input  logic                                s_ack,
    input  logic                                s_err,
    input  logic                                s_rty,
    input  logic [DATA_WIDTH-1:0]               s_dat_i,
    output logic [NUM_MASTERS-1:0]              grant,
    output logic                                timeout_evt
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_MASTERS - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_e        state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  last_owner;
    logic [WDOG_W-1:0] wdog;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   term;
    logic                   owner_cyc;
    logic                   wdog_hit;
    int                     owner_i;

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (m_cyc),
        .last   (last_owner),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign owner_i   = int'(owner);
    assign term      = any_term(s_ack, s_err, s_rty);
    assign owner_cyc = (state == OWNED) && m_cyc[owner];
    assign m_dat_i   = s_dat_i;

    // Ownership FSM: arbitrate only from IDLE, so a release always costs one dead cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= LAST_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= OWNED;
                        grant <= pick_onehot;
                        owner <= pick_idx;
                    end
                end
                OWNED: begin
                    if (!m_cyc[owner]) begin
                        state      <= IDLE;
                        grant      <= '0;
                        last_owner <= owner;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Slave termination in the same cycle as the final count wins over the watchdog.
    assign wdog_hit = owner_cyc && s_stb && !term && (wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog        <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= wdog_hit;
            if (wdog_hit || (state != OWNED) || !s_stb || term) begin
                wdog <= '0;
            end else if (wdog != '1) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

    // Bus mux: the timeout cycle masks the strobe and substitutes an error for the owner.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        s_sel   = '0;
        m_ack   = '0;
        m_err   = '0;
        m_rty   = '0;
        if (state == OWNED) begin
            s_cyc          = m_cyc[owner];
            s_stb          = m_stb[owner] & ~timeout_evt;
            s_we           = m_we[owner];
            s_adr          = m_adr[owner_i*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o        = m_dat_o[owner_i*DATA_WIDTH +: DATA_WIDTH];
            s_sel          = m_sel[owner_i*SELECT_WIDTH +: SELECT_WIDTH];
            m_ack[owner]   = s_ack;
            m_err[owner]   = s_err | timeout_evt;
            m_rty[owner]   = s_rty;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: reset, arbitration, bus lock, routing, watchdog and fairness.
module tb_wb_arbiter_rr;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic              clk;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat_o;
    logic [NM*SW-1:0]  m_sel;
    logic [NM-1:0]     m_ack, m_err, m_rty;
    logic [DW-1:0]     m_dat_i;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel;
    logic              s_ack, s_err, s_rty;
    logic [DW-1:0]     s_dat_i;
    logic [NM-1:0]     grant;
    logic              timeout_evt;

    logic auto_ack;
    logic man_ack;
    int   checks;
    int   failures;

    assign s_ack = auto_ack ? s_stb : man_ack;

    wb_arbiter_rr #(
        .NUM_MASTERS  (NM),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .SELECT_WIDTH (SW),
        .TIMEOUT      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_cyc       (m_cyc),
        .m_stb       (m_stb),
        .m_we        (m_we),
        .m_adr       (m_adr),
        .m_dat_o     (m_dat_o),
        .m_sel       (m_sel),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .m_rty       (m_rty),
        .m_dat_i     (m_dat_i),
        .s_cyc       (s_cyc),
        .s_stb       (s_stb),
        .s_we        (s_we),
        .s_adr       (s_adr),
        .s_dat_o     (s_dat_o),
        .s_sel       (s_sel),
        .s_ack       (s_ack),
        .s_err       (s_err),
        .s_rty       (s_rty),
        .s_dat_i     (s_dat_i),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b want=0000", grant); end
        checks++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin failures++; $display("FAIL reset_s_cyc_stb got=%b%b want=00", s_cyc, s_stb); end
        checks++;
        if (m_ack !== 4'b0000 || m_err !== 4'b0000 || m_rty !== 4'b0000) begin
            failures++; $display("FAIL reset_terms ack=%b err=%b rty=%b want=0", m_ack, m_err, m_rty);
        end
        checks++;
        if (timeout_evt !== 1'b0) begin failures++; $display("FAIL reset_timeout_evt got=%b want=0", timeout_evt); end
        rst_n = 1'b1;
        step();
        // mid-transfer reset: master 1 owns and is being acked
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        auto_ack = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0010 || m_ack !== 4'b0010) begin
            failures++; $display("FAIL pre_reset_owned grant=%b ack=%b want=0010/0010", grant, m_ack);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL midreset_grant got=%b want=0000", grant); end
        checks++;
        if (s_cyc !== 1'b0) begin failures++; $display("FAIL midreset_s_cyc got=%b want=0", s_cyc); end
        checks++;
        if (m_ack !== 4'b0000 || m_err !== 4'b0000) begin
            failures++; $display("FAIL midreset_terms ack=%b err=%b want=0000", m_ack, m_err);
        end
        m_cyc    = '0;
        m_stb    = '0;
        auto_ack = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_arbitration();
        auto_ack = 1'b1;
        m_cyc = 4'b0101;
        m_stb = 4'b0101;
        step();
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("FAIL arb_first got=%b want=0001", grant); end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL arb_dead_cycle got=%b want=0000", grant); end
        step();
        checks++;
        if (grant !== 4'b0100) begin failures++; $display("FAIL arb_second got=%b want=0100", grant); end
        m_cyc = '0;
        m_stb = '0;
        step();
        auto_ack = 1'b0;
    endtask

    task automatic test_lock();
        auto_ack = 1'b1;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0010) begin failures++; $display("FAIL lock_grant1 got=%b want=0010", grant); end
        m_cyc[3] = 1'b1;
        m_stb[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (grant !== 4'b0010) begin failures++; $display("FAIL lock_hold[%0d] got=%b want=0010", i, grant); end
            checks++;
            if (m_ack !== 4'b0010) begin failures++; $display("FAIL lock_ack[%0d] got=%b want=0010", i, m_ack); end
        end
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL lock_release got=%b want=0000", grant); end
        step();
        checks++;
        if (grant !== 4'b1000) begin failures++; $display("FAIL lock_next got=%b want=1000", grant); end
        m_cyc = '0;
        m_stb = '0;
        step();
        auto_ack = 1'b0;
    endtask

    task automatic test_routing();
        logic [31:0] adr_v;
        logic [31:0] dat_v;
        for (int i = 0; i < NM; i++) begin
            adr_v = 32'hA5A5_0000 + i;
            dat_v = 32'h5A5A_0000 + i;
            m_adr[i*AW +: AW]   = adr_v;
            m_dat_o[i*DW +: DW] = dat_v;
            m_sel[i*SW +: SW]   = 4'h1;
        end
        m_adr[2*AW +: AW]   = 32'h1000_0040;
        m_dat_o[2*DW +: DW] = 32'hDEAD_BEEF;
        m_sel[2*SW +: SW]   = 4'hF;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        m_we[2]  = 1'b1;
        man_ack  = 1'b0;
        s_dat_i  = 32'h1234_5678;
        step();
        checks++;
        if (grant !== 4'b0100) begin failures++; $display("FAIL route_grant got=%b want=0100", grant); end
        checks++;
        if (s_adr !== 32'h1000_0040) begin failures++; $display("FAIL route_adr got=%h want=10000040", s_adr); end
        checks++;
        if (s_dat_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL route_dat got=%h want=deadbeef", s_dat_o); end
        checks++;
        if (s_sel !== 4'hF) begin failures++; $display("FAIL route_sel got=%h want=f", s_sel); end
        checks++;
        if (s_we !== 1'b1 || s_stb !== 1'b1 || s_cyc !== 1'b1) begin
            failures++; $display("FAIL route_ctl we/stb/cyc got=%b%b%b want=111", s_we, s_stb, s_cyc);
        end
        checks++;
        if (m_ack !== 4'b0000) begin failures++; $display("FAIL route_noack got=%b want=0000", m_ack); end
        man_ack = 1'b1;
        #1;
        checks++;
        if (m_ack !== 4'b0100) begin failures++; $display("FAIL route_ack got=%b want=0100", m_ack); end
        checks++;
        if (m_dat_i !== 32'h1234_5678) begin failures++; $display("FAIL route_rdata got=%h want=12345678", m_dat_i); end
        step();
        man_ack  = 1'b0;
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = '0;
        step();
    endtask

    task automatic test_timeout();
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("FAIL to_grant got=%b want=0001", grant); end
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) step();
            checks++;
            if (timeout_evt !== 1'b0 || m_err !== 4'b0000 || s_stb !== 1'b1) begin
                failures++;
                $display("FAIL to_wait[%0d] evt=%b err=%b stb=%b want=0/0000/1", c, timeout_evt, m_err, s_stb);
            end
        end
        step();
        checks++;
        if (timeout_evt !== 1'b1) begin failures++; $display("FAIL to_evt got=%b want=1", timeout_evt); end
        checks++;
        if (m_err !== 4'b0001) begin failures++; $display("FAIL to_err got=%b want=0001", m_err); end
        checks++;
        if (s_stb !== 1'b0) begin failures++; $display("FAIL to_stb_mask got=%b want=0", s_stb); end
        for (int c = 10; c <= 16; c++) begin
            step();
            checks++;
            if (timeout_evt !== 1'b0 || s_stb !== 1'b1) begin
                failures++; $display("FAIL to_restart[%0d] evt=%b stb=%b want=0/1", c, timeout_evt, s_stb);
            end
        end
        step();
        man_ack = 1'b1;
        #1;
        checks++;
        if (m_ack !== 4'b0001) begin failures++; $display("FAIL to_late_ack got=%b want=0001", m_ack); end
        step();
        man_ack = 1'b0;
        #1;
        checks++;
        if (timeout_evt !== 1'b0 || m_err !== 4'b0000) begin
            failures++; $display("FAIL to_ack_wins evt=%b err=%b want=0/0000", timeout_evt, m_err);
        end
        m_cyc = '0;
        m_stb = '0;
        step();
        step();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        auto_ack = 1'b1;
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            step();
            checks++;
            if (grant !== exp_g) begin failures++; $display("FAIL fair_grant[%0d] got=%b want=%b", k, grant, exp_g); end
            checks++;
            if (m_ack !== exp_g) begin failures++; $display("FAIL fair_ack[%0d] got=%b want=%b", k, m_ack, exp_g); end
            m_cyc[k % 4] = 1'b0;
            m_stb[k % 4] = 1'b0;
            step();
            checks++;
            if (grant !== 4'b0000) begin failures++; $display("FAIL fair_idle[%0d] got=%b want=0000", k, grant); end
            m_cyc[k % 4] = 1'b1;
            m_stb[k % 4] = 1'b1;
        end
        m_cyc    = '0;
        m_stb    = '0;
        auto_ack = 1'b0;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = '0;
        m_adr    = '0;
        m_dat_o  = '0;
        m_sel    = '0;
        s_err    = 1'b0;
        s_rty    = 1'b0;
        s_dat_i  = '0;
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        test_reset();
        test_arbitration();
        test_lock();
        test_routing();
        test_timeout();
        test_fairness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit reached without completion");
        $fatal(1);
    end

endmodule

// File: doc/wb_arbiter_rr.md
WB_ARBITER_RR -- requirements
Module: wb_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of Wishbone masters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-004 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-005 SHALL have parameter TIMEOUT, default 255, cycles without slave termination before error (1..65535).
REQ-006 SHALL have one clock and an asynchronous, active-low reset; the ports are listed first, below.
REQ-007 SHALL have port clk  input  1  bus clock, all logic rising-edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have ports m_cyc, m_stb, m_we  input  NUM_MASTERS each  per-master cycle, strobe, write enable.
REQ-010 SHALL have ports m_adr  input  NUM_MASTERS*ADDR_WIDTH, m_dat_o  input  NUM_MASTERS*DATA_WIDTH, m_sel  input  NUM_MASTERS*SELECT_WIDTH  packed per-master address, write data, select; master i occupies slice i.
REQ-011 SHALL have ports m_ack, m_err, m_rty  output  NUM_MASTERS each  per-master terminations.
REQ-012 SHALL have port m_dat_i  output  DATA_WIDTH  read data broadcast to all masters.
REQ-013 SHALL have ports s_cyc, s_stb, s_we  output  1 each; s_adr  output  ADDR_WIDTH; s_dat_o  output  DATA_WIDTH; s_sel  output  SELECT_WIDTH  slave-side request.
REQ-014 SHALL have ports s_ack, s_err, s_rty  input  1 each; s_dat_i  input  DATA_WIDTH  slave-side response.
REQ-015 SHALL have port grant  output  NUM_MASTERS  one-hot current owner, all-zero when idle.
REQ-016 SHALL have port timeout_evt  output  1  single-cycle pulse when the watchdog fires.

Function
REQ-017 SHALL implement FSM states IDLE and OWNED.
REQ-018 In IDLE with any m_cyc high, SHALL register the grant at the next edge and enter OWNED; arbitration latency 1 cycle.
REQ-019 Grant SHALL be round-robin: search starts at last_owner+1 modulo NUM_MASTERS, first requesting m_cyc wins.
REQ-020 In OWNED, SHALL hold the grant while m_cyc[owner]=1, regardless of other requests (bus lock for block/RMW cycles).
REQ-021 In OWNED, when m_cyc[owner]=0, SHALL return to IDLE at that edge, clear grant and update last_owner; the next arbitration takes 1 further cycle (one dead cycle between owners).
REQ-022 While OWNED, s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel SHALL combinationally mirror the owner's signals; while IDLE, s_cyc=s_stb=s_we=0 and s_adr, s_dat_o, s_sel=0.
REQ-023 m_ack/m_err/m_rty[owner] SHALL combinationally mirror s_ack/s_err/s_rty while OWNED; all other bits SHALL be 0.
REQ-024 m_dat_i SHALL equal s_dat_i at all times.
REQ-025 Watchdog counter SHALL increment each cycle with s_stb=1 and s_ack|s_err|s_rty=0, and clear otherwise or in IDLE.
REQ-026 When the counter equals TIMEOUT-1 and no termination arrives, SHALL, on the next cycle, assert m_err[owner]=1 and timeout_evt=1 for one cycle, force s_stb=0 that cycle, and clear the counter.
REQ-027 A slave termination in the same cycle as the counter reaching TIMEOUT-1 SHALL win; no timeout fires.
REQ-028 Counter width SHALL be 16 bits; it SHALL never wrap.
REQ-029 Simultaneous requests in IDLE SHALL be resolved solely by REQ-019; a request arriving in the same cycle as the owner's release SHALL wait for IDLE arbitration.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, grant=0, last_owner=NUM_MASTERS-1 (master 0 wins first), watchdog=0, timeout_evt=0; hence s_cyc=s_stb=0 and m_ack/m_err/m_rty=0.
REQ-031 Reset during OWNED SHALL abandon the transfer immediately without issuing any termination.

Structure
REQ-032 FSM state enum and the watchdog counter width constant SHALL reside in shared package wb_arb_pkg.
REQ-033 Round-robin selection SHALL be a sub-module rr_pick (request vector, last_owner in; one-hot and index out, combinational).

Verification
REQ-034 Reset: rst_n=0 mid-transfer -> grant=0, s_cyc=0 same cycle, no m_ack.
REQ-035 Masters 0 and 2 raise cyc together after reset -> grant=0001 one cycle later; after master 0 drops cyc, one idle cycle, then grant=0100.
REQ-036 Lock: master 1 owns, holds cyc across 3 single-word acks while master 3 requests -> grant stays 0010 until m_cyc[1]=0.
REQ-037 Routing: master 2 writes adr=0x1000_0040, dat=0xDEADBEEF, sel=0xF -> slave sees exact values, ack returned only on m_ack[2].
REQ-038 Timeout: TIMEOUT=8, slave never acks -> m_err[owner] and timeout_evt pulse on cycle 9 of stb, s_stb low that cycle.
REQ-039 Fairness: all 4 masters request continuously with 1-word cycles -> grant order 0,1,2,3,0 repeating.
